// File: rtl/neuron_train_seq.sv
// Upstream sequencer for one sigmoid neuron: buffers a training sample, walks the
// neuron through its forward/backward phase encoding and returns y and dZ.
module neuron_train_seq #(
    parameter int N          = 30,
    parameter int BITS       = 16,
    parameter int FWD_CYCLES = 18,
    parameter int BWD_CYCLES = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS-1:0]          in_data,
    input  logic                     train_en,
    output logic                     FP,
    output logic                     BP,
    output logic [N-1:0][BITS-1:0]   x,
    output logic [BITS-1:0]          y_true,
    input  logic [BITS-1:0]          y_in,
    input  logic [BITS-1:0]          dz_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          y_out,
    output logic [BITS-1:0]          dz_out,
    output logic                     busy
);

    localparam int PH_MAX = (FWD_CYCLES > BWD_CYCLES) ? FWD_CYCLES : BWD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = $clog2(N + 1);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        FSETUP = 3'd1,
        FWD    = 3'd2,
        BSETUP = 3'd3,
        BWD    = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [PH_W-1:0]          phase_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     trn_r;
    logic                     fp_r;
    logic                     bp_r;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     busy_r;
    logic [N-1:0][BITS-1:0]   x_r;
    logic [BITS-1:0]          y_true_r;
    logic [BITS-1:0]          y_out_r;
    logic [BITS-1:0]          dz_out_r;
    logic                     in_hs_s;
    logic                     out_hs_s;
    logic                     last_word_s;
    logic                     fwd_last_s;
    logic                     bwd_last_s;
    logic                     dz_capture_s;

    assign in_hs_s      = in_valid & in_ready_r;
    assign out_hs_s     = out_valid_r & out_ready;
    assign last_word_s  = (cnt_r == CNT_W'(N));
    assign fwd_last_s   = (state_r == FWD) && (phase_r == PH_W'(FWD_CYCLES - 1));
    assign bwd_last_s   = (state_r == BWD) && (phase_r == PH_W'(BWD_CYCLES - 1));
    // dZ is taken one cycle after the neuron latches it at the start of BWD
    assign dz_capture_s = (state_r == BWD) && (phase_r == PH_W'(1));

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LOAD: begin
                if (in_hs_s && last_word_s) begin
                    state_next_s = FSETUP;
                end else begin
                    state_next_s = LOAD;
                end
            end
            FSETUP: state_next_s = FWD;
            FWD: begin
                if (fwd_last_s) begin
                    state_next_s = trn_r ? BSETUP : RESULT;
                end else begin
                    state_next_s = FWD;
                end
            end
            BSETUP: state_next_s = BWD;
            BWD: begin
                if (bwd_last_s) begin
                    state_next_s = RESULT;
                end else begin
                    state_next_s = BWD;
                end
            end
            RESULT: begin
                if (out_hs_s) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = RESULT;
                end
            end
            default: state_next_s = LOAD;
        endcase
    end

    // State, phase counter and phase-encoded outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= LOAD;
            phase_r     <= {PH_W{1'b0}};
            fp_r        <= 1'b0;
            bp_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r) begin
                phase_r <= {PH_W{1'b0}};
            end else if ((state_r == FWD) || (state_r == BWD)) begin
                phase_r <= phase_r + PH_W'(1);
            end else begin
                phase_r <= {PH_W{1'b0}};
            end
            fp_r        <= (state_next_s == FWD) || (state_next_s == BSETUP);
            bp_r        <= (state_next_s == BSETUP) || (state_next_s == BWD);
            in_ready_r  <= (state_next_s == LOAD);
            out_valid_r <= (state_next_s == RESULT);
            busy_r      <= (state_next_s != LOAD);
        end
    end

    // Sample buffer: written only by LOAD handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            trn_r    <= 1'b0;
            x_r      <= '0;
            y_true_r <= {BITS{1'b0}};
        end else if (in_hs_s) begin
            if (last_word_s) begin
                y_true_r <= in_data;
                trn_r    <= train_en;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cnt_r == CNT_W'(i)) begin
                        x_r[i] <= in_data;
                    end
                end
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    // Result capture from the neuron
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_out_r  <= {BITS{1'b0}};
            dz_out_r <= {BITS{1'b0}};
        end else begin
            if (fwd_last_s) begin
                y_out_r <= y_in;
                if (!trn_r) begin
                    dz_out_r <= {BITS{1'b0}};
                end
            end
            if (dz_capture_s) begin
                dz_out_r <= dz_in;
            end
        end
    end

    assign FP        = fp_r;
    assign BP        = bp_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign x         = x_r;
    assign y_true    = y_true_r;
    assign y_out     = y_out_r;
    assign dz_out    = dz_out_r;

endmodule

// File: tb/tb_neuron_train_seq.sv
// Directed bench for neuron_train_seq: a cycle-indexed phase model plus a result
// scoreboard filled at load time and drained at the result port.
module tb_neuron_train_seq;

    localparam int N    = 30;
    localparam int BITS = 16;
    localparam int FWDC = 18;
    localparam int BWDC = 33;
    localparam int W    = N * BITS;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [BITS-1:0]        in_data;
    logic                   train_en;
    logic                   FP;
    logic                   BP;
    logic [N-1:0][BITS-1:0] x;
    logic [BITS-1:0]        y_true;
    logic [BITS-1:0]        y_in;
    logic [BITS-1:0]        dz_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITS-1:0]        y_out;
    logic [BITS-1:0]        dz_out;
    logic                   busy;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb_q[$];

    neuron_train_seq #(.N(N), .BITS(BITS), .FWD_CYCLES(FWDC), .BWD_CYCLES(BWDC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .train_en(train_en), .FP(FP), .BP(BP), .x(x), .y_true(y_true), .y_in(y_in),
        .dz_in(dz_in), .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .dz_out(dz_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {FP,BP,out_valid,busy,in_ready} expected k cycles after the label handshake
    function automatic logic [4:0] exp_flags(input int k, input logic trn);
        logic [1:0] ph;
        int         res_k;
        res_k = trn ? (FWDC + BWDC + 3) : (FWDC + 2);
        if (k == 1)                             ph = 2'b00;
        else if (k <= FWDC + 1)                 ph = 2'b10;
        else if (trn && (k == FWDC + 2))        ph = 2'b11;
        else if (trn && (k <= FWDC + 2 + BWDC)) ph = 2'b01;
        else                                    ph = 2'b00;
        return {ph, (k == res_k), 1'b1, 1'b0};
    endfunction

    task automatic run_sample(input logic trn, input bit toggle, input logic [15:0] base,
                              input logic [15:0] step, input logic [15:0] lbl,
                              input logic [15:0] yv, input logic [15:0] dzv,
                              input int hold, input int abort_k);
        logic [W-1:0] xv;
        logic [31:0]  exp_r;
        int           res_k;
        xv = '0;
        out_ready = (hold == 0) ? 1'b1 : 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (toggle) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 16'hBEEF;
            end
            @(negedge clk);
            if (i == 0 || i == N) check("in_ready_load", in_ready, 1'b1);
            in_valid = 1'b1;
            in_data  = (i < N) ? 16'(base + step * 16'(i)) : lbl;
            train_en = (i == N) ? trn : ~trn;
            if (i < N) xv[i*BITS +: BITS] = in_data;
            @(posedge clk);
        end
        sb_q.push_back({yv, trn ? dzv : 16'h0000});
        res_k = trn ? (FWDC + BWDC + 3) : (FWDC + 2);
        for (int k = 1; k <= res_k; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check("rst_flags", {FP, BP, out_valid, busy, in_ready}, 5'b00001);
                check("rst_x", x, '0);
                check("rst_res", {y_out, dz_out}, 32'h0);
                void'(sb_q.pop_back());
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                return;
            end
            check("phase", {FP, BP, out_valid, busy, in_ready}, exp_flags(k, trn));
            if (k == 1) begin
                check("x_load", x, xv);
                check("y_true_load", y_true, lbl);
            end
            in_valid = k[0];
            in_data  = 16'h5A5A;
            y_in     = (k == FWDC + 1) ? yv : 16'h7777;
            dz_in    = (k == FWDC + 4) ? dzv : 16'h8888;
        end
        exp_r = sb_q.pop_front();
        check("result", {y_out, dz_out}, exp_r);
        check("x_result", x, xv);
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            in_valid = h[0];
            check("hold_flags", {FP, BP, out_valid, busy, in_ready}, 5'b00110);
            check("hold_res", {y_out, dz_out}, exp_r);
        end
        if (hold > 0) begin
            check("hold_x", x, xv);
            out_ready = 1'b1;
            in_valid  = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("back_to_load", {FP, BP, out_valid, busy, in_ready}, 5'b00001);
        check("x_after_hs", x, xv);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; train_en = 1'b0;
        y_in = 16'h0000; dz_in = 16'h0000; out_ready = 1'b1;
        #2;
        check("reset_flags", {FP, BP, out_valid, busy, in_ready}, 5'b00001);
        check("reset_x", x, '0);
        check("reset_y_true", y_true, 16'h0000);
        check("reset_res", {y_out, dz_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // training sample and its inference twin
        run_sample(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'h00C0, 16'hFFC0, 0, -1);
        run_sample(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0100, 16'h00C0, 16'hFFC0, 0, -1);
        // gappy load with distinct words
        run_sample(1'b1, 1'b1, 16'h0010, 16'h0001, 16'h0ABC, 16'h1234, 16'h0042, 0, -1);
        // backpressure on the result port
        run_sample(1'b0, 1'b0, 16'h2000, 16'h0101, 16'hF000, 16'h0F0F, 16'h1111, 100, -1);
        run_sample(1'b1, 1'b0, 16'h0300, 16'h0003, 16'h0055, 16'h00AA, 16'hFF00, 20, -1);
        // abort in BWD cycle 10, then a clean sample
        run_sample(1'b1, 1'b0, 16'h4000, 16'h0002, 16'h0077, 16'h0066, 16'h0044, 0, FWDC + 3 + 10);
        run_sample(1'b1, 1'b0, 16'h0500, 16'h0005, 16'h0099, 16'h0321, 16'hFEDC, 0, -1);
        // back-to-back
        run_sample(1'b0, 1'b0, 16'h0600, 16'h0007, 16'h0011, 16'h4444, 16'h3333, 0, -1);
        run_sample(1'b1, 1'b0, 16'h0700, 16'h000B, 16'h0022, 16'h5555, 16'h6666, 0, -1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_train_seq.md
Name: neuron_train_seq

Overview:
- Upstream sequencer for one Neuron_Sigmoid instance.
- Accepts one training sample as a stream of 16-bit words: N input activations, then one label.
- Buffers the sample and drives the neuron's FP/BP phase encoding for fixed cycle counts: forward setup, forward, backward setup, backward.
- Captures the neuron's y and dZ_out and returns them through a valid/ready result port.
- Inference-only samples skip the backward phases.

Parameters:
- N, 30, number of neuron inputs; must be even and ≤ 30.
- BITS, 16, word width; signed 8.8 fixed point.
- FWD_CYCLES, 18, cycles with {FP,BP}=10; default is N/2+3.
- BWD_CYCLES, 33, cycles with {FP,BP}=01; default is N+3.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample word valid.
- in_ready  out  1  sequencer accepts a word this cycle.
- in_data  in  BITS  sample word; words 0..N-1 are x[0..N-1], word N is y_true.
- train_en  in  1  sampled together with word N; 1 = run backward phases.
- FP  out  1  neuron phase bit FP; registered.
- BP  out  1  neuron phase bit BP; registered.
- x  out  [N-1:0][BITS-1:0]  buffered activations to the neuron.
- y_true  out  BITS  buffered label to the neuron.
- y_in  in  BITS  neuron y.
- dz_in  in  BITS  neuron dZ_out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- y_out  out  BITS  captured forward output.
- dz_out  out  BITS  captured dZ; 0 when train_en was 0.
- busy  out  1  high in every state except LOAD.

Behaviour:
Reset:
- state=LOAD, word counter=0.
- x, y_true, y_out, dz_out all zero.
- {FP,BP}=00, in_ready=1, out_valid=0, busy=0.
- Asserting rst mid-phase aborts the sample immediately. No partial result is emitted.

States and transitions:
- LOAD: in_ready=1. Each in_valid&in_ready handshake writes in_data to x[cnt] (cnt<N) or to y_true (cnt==N); cnt then increments.
  - On the word-N handshake: latch train_en into trn_q, clear cnt, go to FSETUP.
  - in_valid low holds state. {FP,BP}=00 throughout.
- FSETUP: exactly 1 cycle with {FP,BP}=00, then go to FWD. in_ready=0 from here until return to LOAD.
- FWD: {FP,BP}=10 for exactly FWD_CYCLES cycles; phase counter counts 0..FWD_CYCLES-1.
  - On the last FWD cycle, y_out<=y_in.
  - Next state is BSETUP if trn_q, else RESULT with dz_out<=0.
- BSETUP: exactly 1 cycle with {FP,BP}=11, then go to BWD.
- BWD: {FP,BP}=01 for exactly BWD_CYCLES cycles.
  - On the second BWD cycle (counter==1), dz_out<=dz_in. This is the cycle after the neuron latches dz.
  - After the last cycle, go to RESULT.
- RESULT: {FP,BP}=00, out_valid=1; y_out and dz_out held stable.
  - On out_valid&out_ready: go to LOAD, out_valid<=0, in_ready<=1.
  - out_ready low holds indefinitely (backpressure); no new sample is accepted.

Rules:
- FP and BP come from registers, never from combinational state decode, so they are glitch-free at the neuron.
- x and y_true are stable from FSETUP through RESULT. They are written only in LOAD.
- Phase counter width is $clog2(max(FWD_CYCLES,BWD_CYCLES)+1). The counter clears on every state change; no wrap-around within a phase.
- in_valid outside LOAD is ignored (in_ready=0); no data is written.
- out_ready while out_valid=0 has no effect.
- Sample latency from word-N handshake to out_valid:
  - train: 1+FWD_CYCLES+1+BWD_CYCLES+1 = 54 cycles at defaults.
  - inference: FWD_CYCLES+2 = 20 cycles.

Test Plan:
- Reset mid-BWD (cycle 10): assert rst -> FP=BP=0, out_valid=0, busy=0, in_ready=1 on the same edge; the next full sample then runs normally.
- Load x[i]=16'h0100, y_true=16'h0100, train_en=1, neuron model returning y_in=16'h00C0, dz_in=16'hFFC0 -> FP/BP sequence 00(1), 10(18), 11(1), 01(33); out_valid 54 cycles after word 30; y_out=16'h00C0, dz_out=16'hFFC0.
- Same sample with train_en=0 -> BP never high; out_valid after 20 cycles; dz_out=16'h0000.
- in_valid toggled 1/0 every cycle during load -> exactly 31 words captured in order; x[29] = the 30th accepted word; FSETUP entered on the cycle after the 31st handshake.
- Hold out_ready=0 for 100 cycles in RESULT -> out_valid, y_out and dz_out stable; in_valid pulses ignored with in_ready=0. Raising out_ready -> LOAD next cycle.
- Back-to-back samples with out_ready tied 1 -> second sample's x visible only after the first result handshake; no overlap of FP/BP phases.
